reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised successor to the CPU register file. It provides DATA_W-wide general registers with NUM_RD registered read ports, one write port and a link write. The top index is aliased to the program counter. A per-register pending scoreboard lets the decode stage stall on in-flight writebacks. It sits between decode (read addresses, scoreboard set) and writeback (write port, link).

Parameters:
DATA_W, 32, register and data width
ADDR_W, 4, register address width; index 2**ADDR_W-1 is the PC alias
NUM_RD, 3, number of read ports
LINK_IDX, 14, register written by link

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
pc_content  input  DATA_W  current PC value, returned on PC-alias reads and stored by link
reg_write  input  1  write enable
write_addr  input  ADDR_W  write index
write_data  input  DATA_W  write value
link  input  1  store pc_content into LINK_IDX
read_addr  input  NUM_RD*ADDR_W  port i address at bits [i*ADDR_W +: ADDR_W]
read_data  output  NUM_RD*DATA_W  port i data at bits [i*DATA_W +: DATA_W]
read_is_pc  output  NUM_RD  port i read the PC alias
read_pending  output  NUM_RD  port i register has a pending writeback
sb_set  input  1  mark sb_addr as pending
sb_addr  input  ADDR_W  scoreboard set index
any_pending  output  1  OR of all pending bits

Behaviour:
- Storage: registers 0 .. 2**ADDR_W-2, each DATA_W wide. PC_IDX = 2**ADDR_W-1 has no storage.
- Reset (rst low, async):
  - All registers and pending bits go to 0.
  - read_data, read_is_pc, read_pending and any_pending go to 0.
  - Reset mid-operation discards same-cycle writes, links and sets.
- Write, on the rising edge:
  - reg_write with write_addr != PC_IDX writes write_data.
  - reg_write to PC_IDX is ignored; the register contents do not change.
- Link, on the rising edge: link writes pc_content into LINK_IDX.
  - If link and reg_write both target LINK_IDX in the same cycle, link wins.
- Read latency is 1 cycle: read_addr is sampled at edge N and the result appears after edge N.
  - Port with address PC_IDX: read_data = pc_content sampled at that edge; read_is_pc = 1; read_pending = 0.
  - Otherwise: read_data = register value; read_is_pc = 0.
  - Per-port flags are independent. There is no shared pc flag.
- Bypass (see Optional Feature): a read of the address being written or linked in the same cycle returns the new value. Link takes priority, as for the write.
- Scoreboard:
  - pending[i] is cleared by a reg_write to i, or by link when i = LINK_IDX.
  - pending[i] is set by sb_set with sb_addr = i.
  - If set and clear hit the same index in the same cycle, set wins (new producer).
  - sb_set to PC_IDX is ignored.
- read_pending timing: read_pending[p] is registered with read_data. It reflects pending after that cycle's clears but before that cycle's set, consistent with the bypass.
- any_pending is registered and reflects the pending bits after the full update.
- There are no illegal states. All address values are legal.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined: same-cycle write/link-to-read forwarding as above. read_pending uses the post-clear value.
- Undefined: reads return the pre-edge register contents (old value). read_pending uses the pre-edge pending bit, so a same-cycle clear is not visible until the next read. Writes and the scoreboard update identically in both builds.

Test Plan:
- Reset with rst=0 after writes -> all read_data = 0 and any_pending = 0. Reads after release return 0 for r0..r14.
- Write r3=0xDEADBEEF, then read port1 addr 3 -> read_data[port1] = 0xDEADBEEF one cycle later, read_is_pc = 3'b000. Port2 reading addr 15 with pc_content = 0x100 -> 0x100, read_is_pc = 3'b100.
- Same cycle: reg_write r5=0x55, read port0 addr 5 (r5 previously 0x11) -> 0x55 with REG_FILE_BYPASS_EN, 0x11 without it. Next read is 0x55 in both builds.
- Same cycle: link with pc_content = 0x200 and reg_write r14=0x999 -> r14 = 0x200. reg_write to addr 15 -> no register changes.
- sb_set r7, then read r7 -> read_pending = 1 and any_pending = 1. Write r7 while sb_set r7 in the same cycle -> r7 stays pending. A later write r7 alone -> pending cleared and any_pending = 0.
- Assert rst low mid-write and mid-sb_set -> next read of the target returns 0 and it is not pending.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// -----------------------------------------------------------------------------
// reg_file_sb_if
//
// Purpose: bundles the decode/writeback-facing signals of the scoreboarded
//          register file so that the register file and its user connect
//          through one port each.
//
// Signals (direction given from the register file's point of view):
//   pc_content    in   DATA_W         current PC. Returned on PC-alias reads
//                                     and stored by link.
//   reg_write     in   1              write enable
//   write_addr    in   ADDR_W         write index
//   write_data    in   DATA_W         write value
//   link          in   1              store pc_content into the link register
//   read_addr     in   NUM_RD*ADDR_W  port i address at [i*ADDR_W +: ADDR_W]
//   read_data     out  NUM_RD*DATA_W  port i data at [i*DATA_W +: DATA_W]
//   read_is_pc    out  NUM_RD         port i read the PC alias
//   read_pending  out  NUM_RD         port i register awaits a writeback
//   sb_set        in   1              mark sb_addr as pending
//   sb_addr       in   ADDR_W         scoreboard set index
//   any_pending   out  1              OR of all pending bits
//
// Modports:
//   master - decode/writeback side (drives requests, observes results)
//   slave  - register file side
// -----------------------------------------------------------------------------
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3
);

  logic [DATA_W-1:0]        pc_content;
  logic                     reg_write;
  logic [ADDR_W-1:0]        write_addr;
  logic [DATA_W-1:0]        write_data;
  logic                     link;
  logic [NUM_RD*ADDR_W-1:0] read_addr;
  logic [NUM_RD*DATA_W-1:0] read_data;
  logic [NUM_RD-1:0]        read_is_pc;
  logic [NUM_RD-1:0]        read_pending;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     any_pending;

  modport master (
    output pc_content, reg_write, write_addr, write_data, link,
           read_addr, sb_set, sb_addr,
    input  read_data, read_is_pc, read_pending, any_pending
  );

  modport slave (
    input  pc_content, reg_write, write_addr, write_data, link,
           read_addr, sb_set, sb_addr,
    output read_data, read_is_pc, read_pending, any_pending
  );

endinterface

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Purpose: general-purpose register file with a pending-writeback scoreboard.
//   - Registers 0 .. 2**ADDR_W-2 hold DATA_W-bit values.
//   - Index 2**ADDR_W-1 is the PC alias. It has no storage. Reading it
//     returns pc_content, and writes or scoreboard sets to it are dropped.
//   - There is one write port and a link write. Link stores pc_content into
//     LINK_IDX and beats a same-cycle write to the same register.
//   - NUM_RD read ports are registered, so results appear one cycle after
//     the address is sampled.
//   - The per-register pending bit is cleared by a write or link to that
//     register and set by sb_set. A set beats a same-cycle clear.
//
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  asynchronous, active-low reset
//   bus   reg_file_sb_if.slave  decode/writeback signals (see the interface)
//
// Configuration macro REG_FILE_BYPASS_EN:
//   defined   - a read in the same cycle as a write or link to its register
//               returns the new value. read_pending sees that cycle's clear.
//   undefined - reads return the contents from before the edge. read_pending
//               uses the pending bit from before the edge.
//   Storage and scoreboard updates are identical in both builds.
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 3,
  parameter int LINK_IDX = 14
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  localparam int              NREG   = 2**ADDR_W;
  localparam int              NSTORE = NREG - 1;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);

  // Architectural state
  logic [DATA_W-1:0]        r_regs [NSTORE];
  logic [NSTORE-1:0]        r_pending;

  // Registered read results
  logic [NUM_RD*DATA_W-1:0] r_read_data;
  logic [NUM_RD-1:0]        r_read_is_pc;
  logic [NUM_RD-1:0]        r_read_pending;
  logic                     r_any_pending;

  // Next-state and read-view nets
  logic                     w_wr_en;
  logic [DATA_W-1:0]        w_reg_nxt  [NSTORE];
  logic [NSTORE-1:0]        w_pend_clr;
  logic [NSTORE-1:0]        w_pend_nxt;
  logic [DATA_W-1:0]        w_rd_view  [NREG];
  logic [NREG-1:0]          w_pend_view;

  // ---- Stage: next register contents and scoreboard update ----
  // Link is applied after the write so that it takes priority on LINK_IDX.
  // The post-clear pending vector is kept separate. The bypassing read path
  // needs it, and a set must override it.
  always_comb begin
    w_wr_en = bus.reg_write && (bus.write_addr != PC_IDX);
    for (int i = 0; i < NSTORE; i++) begin
      w_reg_nxt[i]  = r_regs[i];
      w_pend_clr[i] = r_pending[i];
      if (w_wr_en && (bus.write_addr == ADDR_W'(i))) begin
        w_reg_nxt[i]  = bus.write_data;
        w_pend_clr[i] = 1'b0;
      end
      if (bus.link && (LINK_A == ADDR_W'(i))) begin
        w_reg_nxt[i]  = bus.pc_content;
        w_pend_clr[i] = 1'b0;
      end
      // A set to PC_IDX has no bit here, so it falls away naturally.
      w_pend_nxt[i] = w_pend_clr[i] |
                      (bus.sb_set && (bus.sb_addr == ADDR_W'(i)));
    end
  end

  // ---- Stage: what a read port sees this cycle ----
  // This is a full 2**ADDR_W entry table. Its top entry is the PC alias, so
  // every address indexes in range.
  always_comb begin
    for (int i = 0; i < NSTORE; i++) begin
`ifdef REG_FILE_BYPASS_EN
      w_rd_view[i]   = w_reg_nxt[i];
      w_pend_view[i] = w_pend_clr[i];
`else
      w_rd_view[i]   = r_regs[i];
      w_pend_view[i] = r_pending[i];
`endif
    end
    w_rd_view[NREG-1]   = bus.pc_content;
    w_pend_view[NREG-1] = 1'b0;
  end

  // ---- Stage: register update and registered read ports ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSTORE; i++) begin
        r_regs[i] <= '0;
      end
      r_pending      <= '0;
      r_read_data    <= '0;
      r_read_is_pc   <= '0;
      r_read_pending <= '0;
      r_any_pending  <= 1'b0;
    end else begin
      for (int i = 0; i < NSTORE; i++) begin
        r_regs[i] <= w_reg_nxt[i];
      end
      r_pending     <= w_pend_nxt;
      r_any_pending <= |w_pend_nxt;
      for (int p = 0; p < NUM_RD; p++) begin
        r_read_data[p*DATA_W +: DATA_W] <= w_rd_view[bus.read_addr[p*ADDR_W +: ADDR_W]];
        r_read_is_pc[p]   <= (bus.read_addr[p*ADDR_W +: ADDR_W] == PC_IDX);
        r_read_pending[p] <= w_pend_view[bus.read_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign bus.read_data    = r_read_data;
  assign bus.read_is_pc   = r_read_is_pc;
  assign bus.read_pending = r_read_pending;
  assign bus.any_pending  = r_any_pending;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Purpose: directed self-checking bench for reg_file_sb. The expected values
// are worked out by hand. Where the two builds differ, the expectation
// depends on REG_FILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) bus ();

  reg_file_sb #(
    .DATA_W(32), .ADDR_W(4), .NUM_RD(3), .LINK_IDX(14)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reg_write  = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    bus.link       = 1'b0;
    bus.sb_set     = 1'b0;
    bus.sb_addr    = '0;
  endtask

  task automatic rd3(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    bus.read_addr = {a2, a1, a0};
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.reg_write  = 1'b1;
    bus.write_addr = a;
    bus.write_data = d;
  endtask

  function automatic logic [31:0] rd(input int p);
    return bus.read_data[p*32 +: 32];
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    idle();
    bus.pc_content = 32'h100;
    rd3(4'd0, 4'd0, 4'd0);
    tick();
    tick();
    rst = 1'b1;

    // Fill some state, then hit it with an async reset
    wr(4'd1, 32'hAAAA);
    bus.sb_set  = 1'b1;
    bus.sb_addr = 4'd2;
    rd3(4'd15, 4'd15, 4'd15);
    tick();
    idle();
    tick();
    chk("pre_rst_anypend", bus.any_pending, 1);
    chk("pre_rst_is_pc", bus.read_is_pc, 3'b111);
    chk("pre_rst_data", rd(0), 32'h100);
    rst = 1'b0;
    #1;
    chk("rst_data", bus.read_data, 0);
    chk("rst_is_pc", bus.read_is_pc, 0);
    chk("rst_pend", bus.read_pending, 0);
    chk("rst_anypend", bus.any_pending, 0);
    #2;
    rst = 1'b1;

    // Read every stored register after reset release
    for (int c = 0; c < 5; c++) begin
      rd3(4'(3*c), 4'(3*c+1), 4'(3*c+2));
      tick();
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("post_rst_r%0d", 3*c+p), rd(p), 0);
        chk($sformatf("post_rst_pend_r%0d", 3*c+p), bus.read_pending[p], 0);
      end
    end

    // Plain write, then read it back; the PC alias on port 2
    wr(4'd3, 32'hDEADBEEF);
    rd3(4'd0, 4'd0, 4'd0);
    tick();
    idle();
    rd3(4'd3, 4'd3, 4'd3);
    tick();
    chk("r3_p1", rd(1), 32'hDEADBEEF);
    chk("r3_is_pc", bus.read_is_pc, 3'b000);
    rd3(4'd0, 4'd3, 4'd15);
    tick();
    chk("r3_p1_b", rd(1), 32'hDEADBEEF);
    chk("pc_p2", rd(2), 32'h100);
    chk("pc_is_pc", bus.read_is_pc, 3'b100);

    // Same-cycle write and read of r5
    wr(4'd5, 32'h11);
    tick();
    wr(4'd5, 32'h55);
    rd3(4'd5, 4'd0, 4'd0);
    tick();
    chk("r5_same_cyc", rd(0), BYP ? 32'h55 : 32'h11);
    idle();
    tick();
    chk("r5_next", rd(0), 32'h55);

    // Link beats a write to r14
    bus.pc_content = 32'h200;
    bus.link = 1'b1;
    wr(4'd14, 32'h999);
    rd3(4'd14, 4'd0, 4'd0);
    tick();
    chk("link_same_cyc", rd(0), BYP ? 32'h200 : 32'h0);
    idle();
    bus.pc_content = 32'h300;
    tick();
    chk("link_r14", rd(0), 32'h200);

    // A write to the PC alias changes nothing; the flags are per port
    wr(4'd15, 32'h12345678);
    rd3(4'd15, 4'd5, 4'd14);
    tick();
    chk("pcw_is_pc", bus.read_is_pc, 3'b001);
    chk("pcw_p0", rd(0), 32'h300);
    idle();
    rd3(4'd3, 4'd5, 4'd14);
    tick();
    chk("pcw_r3", rd(0), 32'hDEADBEEF);
    chk("pcw_r5", rd(1), 32'h55);
    chk("pcw_r14", rd(2), 32'h200);

    // Scoreboard
    bus.sb_set  = 1'b1;
    bus.sb_addr = 4'd7;
    rd3(4'd7, 4'd0, 4'd0);
    tick();
    chk("sb_set_cyc_pend", bus.read_pending[0], 0);
    chk("sb_set_any", bus.any_pending, 1);
    idle();
    tick();
    chk("sb_r7_pend", bus.read_pending, 3'b001);
    chk("sb_r7_any", bus.any_pending, 1);
    wr(4'd7, 32'h77);
    bus.sb_set  = 1'b1;
    bus.sb_addr = 4'd7;
    tick();
    chk("sb_wr_set_pend", bus.read_pending[0], BYP ? 1'b0 : 1'b1);
    chk("sb_wr_set_data", rd(0), BYP ? 32'h77 : 32'h0);
    idle();
    tick();
    chk("sb_still_pend", bus.read_pending[0], 1);
    chk("sb_still_any", bus.any_pending, 1);
    chk("sb_r7_data", rd(0), 32'h77);
    wr(4'd7, 32'h78);
    tick();
    chk("sb_clr_pend", bus.read_pending[0], BYP ? 1'b0 : 1'b1);
    chk("sb_clr_any", bus.any_pending, 0);
    idle();
    tick();
    chk("sb_clr_pend_next", bus.read_pending[0], 0);
    chk("sb_clr_data", rd(0), 32'h78);

    // Reset lands on a write and a set; both must be discarded
    wr(4'd9, 32'h9999);
    bus.sb_set  = 1'b1;
    bus.sb_addr = 4'd10;
    rd3(4'd9, 4'd10, 4'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle();
    tick();
    chk("mid_rst_r9", rd(0), 0);
    chk("mid_rst_r10", rd(1), 0);
    chk("mid_rst_r3", rd(2), 0);
    chk("mid_rst_pend", bus.read_pending, 0);
    chk("mid_rst_any", bus.any_pending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
